// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide controller: width, op and state encodings.
// DATA_WIDTH may be overridden by defining the DATA_WIDTH macro.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package div_ctrl_pkg;

  localparam int DIV_DATA_WIDTH = `DATA_WIDTH;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    WAIT = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  function automatic logic op_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_ctrl_abs.sv
// Conditional two's-complement negate used for operand magnitudes
// and for restoring the sign of quotient and remainder.
module div_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? -a : a;

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer wrapping an external unsigned divider.
// Optional DIV_RESULT_CACHE_EN keeps the last normal-path result for reuse.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  div_req,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] div_src1,
  input  logic [DATA_WIDTH-1:0] div_src2,
  input  logic                  div_flush,
  output logic                  div_busy,
  output logic                  div_valid,
  output logic [DATA_WIDTH-1:0] div_out,
  output logic                  du_start,
  output logic [DATA_WIDTH-1:0] du_src1,
  output logic [DATA_WIDTH-1:0] du_src2,
  input  logic                  du_done,
  input  logic [DATA_WIDTH-1:0] du_div_result,
  input  logic [DATA_WIDTH-1:0] du_rem_result
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] src1_q, src1_d;
  logic [DATA_WIDTH-1:0] src2_q, src2_d;
  logic [DATA_WIDTH-1:0] dsrc1_q, dsrc1_d;
  logic [DATA_WIDTH-1:0] dsrc2_q, dsrc2_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  qsign_q, qsign_d;
  logic                  rsign_q, rsign_d;
  logic                  norm_q, norm_d;
  logic                  start_q, start_d;
  logic                  valid_q, valid_d;

  logic                  s1, s2;
  logic [DATA_WIDTH-1:0] mag1, mag2, quo_fix, rem_fix;

`ifdef DIV_RESULT_CACHE_EN
  logic                  c_vld_q, c_vld_d;
  logic                  c_sgn_q, c_sgn_d;
  logic [DATA_WIDTH-1:0] c_src1_q, c_src1_d;
  logic [DATA_WIDTH-1:0] c_src2_q, c_src2_d;
  logic [DATA_WIDTH-1:0] c_quo_q, c_quo_d;
  logic [DATA_WIDTH-1:0] c_rem_q, c_rem_d;
  logic                  hit;

  assign hit = c_vld_q && (div_src1 == c_src1_q) &&
               (div_src2 == c_src2_q) &&
               (op_signed(div_op) == c_sgn_q);
`endif

  assign s1 = op_signed(op_q) & src1_q[DATA_WIDTH-1];
  assign s2 = op_signed(op_q) & src2_q[DATA_WIDTH-1];

  div_abs #(.W(DATA_WIDTH)) u_abs1 (.a(src1_q), .neg(s1), .y(mag1));
  div_abs #(.W(DATA_WIDTH)) u_abs2 (.a(src2_q), .neg(s2), .y(mag2));
  div_abs #(.W(DATA_WIDTH)) u_fixq (.a(quo_q), .neg(qsign_q), .y(quo_fix));
  div_abs #(.W(DATA_WIDTH)) u_fixr (.a(rem_q), .neg(rsign_q), .y(rem_fix));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dsrc1_d = dsrc1_q;
    dsrc2_d = dsrc2_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    out_d   = out_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    norm_d  = norm_q;
    valid_d = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
    c_vld_d  = c_vld_q;
    c_sgn_d  = c_sgn_q;
    c_src1_d = c_src1_q;
    c_src2_d = c_src2_q;
    c_quo_d  = c_quo_q;
    c_rem_d  = c_rem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (div_req) begin
          op_d    = div_op;
          src1_d  = div_src1;
          src2_d  = div_src2;
          qsign_d = 1'b0;
          rsign_d = 1'b0;
          norm_d  = 1'b0;
          if (div_src2 == '0) begin
            quo_d   = '1;
            rem_d   = div_src1;
            state_d = FIX;
          end else if (op_signed(div_op) && div_src1 == MIN_NEG &&
                       div_src2 == '1) begin
            quo_d   = div_src1;
            rem_d   = '0;
            state_d = FIX;
          end
`ifdef DIV_RESULT_CACHE_EN
          else if (hit) begin
            quo_d   = c_quo_q;
            rem_d   = c_rem_q;
            state_d = FIX;
          end
`endif
          else begin
            norm_d  = 1'b1;
            state_d = PREP;
          end
        end
      end
      PREP: begin
        dsrc1_d = mag1;
        dsrc2_d = mag2;
        qsign_d = s1 ^ s2;
        rsign_d = s1;
        state_d = WAIT;
      end
      WAIT: begin
        if (du_done) begin
          quo_d   = du_div_result;
          rem_d   = du_rem_result;
          state_d = FIX;
        end
      end
      FIX: begin
        valid_d = 1'b1;
        out_d   = op_rem(op_q) ? rem_fix : quo_fix;
        state_d = IDLE;
`ifdef DIV_RESULT_CACHE_EN
        if (norm_q) begin
          c_vld_d  = 1'b1;
          c_sgn_d  = op_signed(op_q);
          c_src1_d = src1_q;
          c_src2_d = src2_q;
          c_quo_d  = quo_fix;
          c_rem_d  = rem_fix;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including a request arriving in IDLE.
    if (div_flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      op_d    = op_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      out_d   = out_q;
`ifdef DIV_RESULT_CACHE_EN
      c_vld_d = 1'b0;
`endif
    end
    start_d = (state_d == WAIT);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= IDLE;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dsrc1_q <= '0;
      dsrc2_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      norm_q  <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
      c_vld_q  <= 1'b0;
      c_sgn_q  <= 1'b0;
      c_src1_q <= '0;
      c_src2_q <= '0;
      c_quo_q  <= '0;
      c_rem_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dsrc1_q <= dsrc1_d;
      dsrc2_q <= dsrc2_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      norm_q  <= norm_d;
      start_q <= start_d;
      valid_q <= valid_d;
`ifdef DIV_RESULT_CACHE_EN
      c_vld_q  <= c_vld_d;
      c_sgn_q  <= c_sgn_d;
      c_src1_q <= c_src1_d;
      c_src2_q <= c_src2_d;
      c_quo_q  <= c_quo_d;
      c_rem_q  <= c_rem_d;
`endif
    end
  end

  assign div_busy  = (state_q != IDLE);
  assign div_valid = valid_q;
  assign div_out   = out_q;
  assign du_start  = start_q;
  assign du_src1   = dsrc1_q;
  assign du_src2   = dsrc2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural unsigned divider
// and a scoreboard queue of expected results.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 3;
`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_E = 1;
  localparam int HIT_S = 0;
`else
  localparam int HIT_E = 2 + LAT;
  localparam int HIT_S = LAT;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic         div_req;
  logic [1:0]   div_op;
  logic [W-1:0] div_src1, div_src2;
  logic         div_flush;
  logic         div_busy, div_valid;
  logic [W-1:0] div_out;
  logic         du_start;
  logic [W-1:0] du_src1, du_src2;
  logic         du_done;
  logic [W-1:0] du_div_result, du_rem_result;

  int checks   = 0;
  int failures = 0;
  int cnt      = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  div_ctrl #(.DATA_WIDTH(W)) dut (
    .cpu_clk      (clk),
    .cpu_rstn     (rstn),
    .div_req      (div_req),
    .div_op       (div_op),
    .div_src1     (div_src1),
    .div_src2     (div_src2),
    .div_flush    (div_flush),
    .div_busy     (div_busy),
    .div_valid    (div_valid),
    .div_out      (div_out),
    .du_start     (du_start),
    .du_src1      (du_src1),
    .du_src2      (du_src2),
    .du_done      (du_done),
    .du_div_result(du_div_result),
    .du_rem_result(du_rem_result)
  );

  // Unsigned divider model: done after LAT cycles of start held high.
  always @(negedge clk) begin
    if (!du_start) begin
      cnt     = 0;
      du_done = 1'b0;
    end else begin
      cnt++;
      du_done = (cnt == LAT);
      if (cnt == LAT) begin
        du_div_result = (du_src2 == 0) ? '1 : du_src1 / du_src2;
        du_rem_result = (du_src2 == 0) ? du_src1 : du_src1 % du_src2;
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_edges,
                        input int exp_starts);
    int n;
    int starts;
    int bad;
    logic got;
    logic [W-1:0] e;
    n = 0; starts = 0; bad = 0; got = 1'b0;
    @(negedge clk);
    div_req  = 1'b1;
    div_op   = op;
    div_src1 = a;
    div_src2 = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 div_req = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (du_start) starts++;
      if (du_start && !div_busy) bad++;
      if (div_valid) got = 1'b1;
    end
    chk({tag, "_seen"}, W'(got), W'(1));
    if (got) begin
      e = exp_q.pop_front();
      chk({tag, "_out"}, div_out, e);
      chk({tag, "_edges"}, W'(n - 1), W'(exp_edges));
      chk({tag, "_starts"}, W'(starts), W'(exp_starts));
      chk({tag, "_startbusy"}, W'(bad), W'(0));
      @(negedge clk);
      chk({tag, "_pulse"}, W'(div_valid), W'(0));
      chk({tag, "_hold"}, div_out, e);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic wait_start(output logic ok);
    int n;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      n++;
      ok = du_start;
    end
  endtask

  initial begin
    int vc;
    logic ok;
    rstn = 1'b0; div_req = 1'b0; div_op = '0;
    div_src1 = '0; div_src2 = '0; div_flush = 1'b0;
    du_done = 1'b0; du_div_result = '0; du_rem_result = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", W'(div_valid), W'(0));
    chk("rst_out", div_out, '0);
    chk("rst_busy", W'(div_busy), W'(0));
    chk("rst_start", W'(du_start), W'(0));
    chk("rst_dsrc1", du_src1, '0);
    rstn = 1'b1;
    @(negedge clk);

    run_op("div_m7_2", OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 2 + LAT, LAT);
    run_op("rem_m7_2", OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, HIT_E, HIT_S);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 2 + LAT, LAT);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, HIT_E, HIT_S);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

    // Flush while the divider is running.
    @(negedge clk);
    div_req = 1'b1; div_op = OP_DIVU;
    div_src1 = 32'd1000; div_src2 = 32'd3;
    @(posedge clk);
    #1 div_req = 1'b0;
    wait_start(ok);
    chk("flush_reach_wait", W'(ok), W'(1));
    div_flush = 1'b1;
    @(posedge clk);
    #1 div_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", W'(div_busy), W'(0));
    chk("flush_start", W'(du_start), W'(0));
    vc = 0;
    repeat (6) begin
      if (div_valid) vc++;
      @(negedge clk);
    end
    chk("flush_novalid", W'(vc), W'(0));
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 2 + LAT, LAT);

    run_op("div_50_m7", OP_DIV, 32'd50, -32'sd7, 32'hFFFF_FFF9,
           2 + LAT, LAT);
    run_op("rem_50_m7", OP_REM, 32'd50, -32'sd7, 32'd1, HIT_E, HIT_S);

    // Reset asserted mid-operation.
    @(negedge clk);
    div_req = 1'b1; div_op = OP_DIVU;
    div_src1 = 32'd77; div_src2 = 32'd5;
    @(posedge clk);
    #1 div_req = 1'b0;
    wait_start(ok);
    chk("rst_reach_wait", W'(ok), W'(1));
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", W'(div_busy), W'(0));
    chk("rst_mid_start", W'(du_start), W'(0));
    chk("rst_mid_out", div_out, '0);
    chk("rst_mid_dsrc2", du_src2, '0);
    @(negedge clk);
    rstn = 1'b1;
    vc = 0;
    repeat (8) begin
      @(negedge clk);
      if (div_valid) vc++;
    end
    chk("rst_mid_novalid", W'(vc), W'(0));
    chk("sb_empty", W'(exp_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
